clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-set controller for the HH:MM:SS 12-hour clock datapath. Gates the 1 Hz run enable
//  to the counters and runs a button-driven set sequence (hours, then minutes), with auto-repeat.
//  Ends with a one-cycle parallel load of HH:MM:00 and the PM flag into the counters.
//  Sits between the tick generator/button synchronisers and the clock counter block.
// PARAMETERS
//  REPEAT_DLY  25_000_000  cycles inc must be held after first step before auto-repeat starts
//  REPEAT_CYC  5_000_000   cycles between auto-repeat steps while inc stays held
//  TIMEOUT     30          1 Hz ticks with no button edge in a set state before abort
// PORTS
//  i_clk       in   1  system clock
//  i_rst       in   1  reset, asynchronous, active-low
//  i_tick      in   1  one-cycle 1 Hz pulse
//  i_btn_mode  in   1  mode button, synchronised/debounced level, active-high
//  i_btn_inc   in   1  increment button, synchronised/debounced level, active-high
//  i_hh        in   8  current hours, BCD 8'h00..8'h11
//  i_mm        in   8  current minutes, BCD 8'h00..8'h59
//  i_pm        in   1  current PM flag
//  o_clk_en    out  1  run enable to counters = i_tick & (state==RUN) & i_rst (combinational)
//  o_ld        out  1  one-cycle parallel-load strobe to counters
//  o_ld_hh     out  8  BCD hours to load (shadow)
//  o_ld_mm     out  8  BCD minutes to load (shadow)
//  o_ld_ss     out  8  seconds to load, constant 8'h00
//  o_ld_pm     out  1  PM flag to load (shadow)
//  o_mode      out  2  state code: 0 RUN, 1 SET_HH, 2 SET_MM, 3 COMMIT
//  o_blank_hh  out  1  display blank for hours digits (blink)
//  o_blank_mm  out  1  display blank for minutes digits (blink)
// BEHAVIOUR
//  Reset: state RUN; o_ld=0, o_ld_hh=o_ld_mm=8'h00, o_ld_pm=0, o_blank_*=0; edge regs and
//   repeat/timeout counters cleared. All outputs registered except o_clk_en and o_ld_ss.
//  Edge detect: mode_p / inc_p = rising edge of level vs. previous-cycle sample.
//  RUN: o_clk_en passes i_tick. On mode_p: shadow<=i_hh/i_mm/i_pm; next state SET_HH.
//  SET_HH: o_clk_en=0. inc step: hh BCD+1; 8'h09->8'h10; 8'h11->8'h00 toggles shadow pm.
//   mode_p -> SET_MM.
//  SET_MM: o_clk_en=0. inc step: mm BCD+1; x9 carries to tens; 8'h59->8'h00, no carry to hh.
//   mode_p -> COMMIT.
//  COMMIT: lasts exactly one cycle; o_ld=1 with shadow values, ss=8'h00; next state RUN.
//   o_ld is 0 in every other state. First counting tick follows in RUN.
//  Inc step = inc_p, or auto-repeat. Auto-repeat: hold counter counts cycles while i_btn_inc
//   stays high in a set state. After REPEAT_DLY cycles from the edge, one step fires, then one
//   every REPEAT_CYC cycles. Release or state change clears the hold counter.
//  Simultaneous mode_p and inc step in the same cycle: mode wins, no increment.
//  Timeout: counter clears on any mode_p/inc_p and on entering SET_HH. It increments on i_tick
//   in SET_HH/SET_MM. On reaching TIMEOUT: next state RUN, no load, shadow discarded, and
//   counters resume from the held time.
//  Blink: a toggle flop flips on i_tick in set states and is cleared in RUN/COMMIT.
//   o_blank_hh = toggle & SET_HH; o_blank_mm = toggle & SET_MM. The toggle is forced to 0 on
//   every inc step, so the digit shows while editing.
//  Mode held: only one transition per press, edge only; no auto-repeat on mode.
//  Async reset mid-set: immediate return to RUN, any pending load lost, no o_ld pulse.
// TESTING
//  Params REPEAT_DLY=8, REPEAT_CYC=4, TIMEOUT=3; tick every 10 cycles.
//  1 RUN, 5 ticks -> o_clk_en pulses 5 times aligned with i_tick; o_ld never asserts; o_mode=0.
//  2 i_hh=8'h10,i_mm=8'h58,i_pm=0; mode, inc x2, mode, inc x2, mode -> exactly one o_ld cycle
//    with hh=8'h00, pm=1, mm=8'h00, ss=8'h00; then o_mode=0 and o_clk_en resumes.
//  3 SET_MM from 8'h07, hold inc 20 cycles -> steps at edge, +8, +12, +16, +20: mm=8'h12.
//  4 SET_HH, mode and inc rising in same cycle -> o_mode=2, shadow hh unchanged.
//  5 SET_HH idle 3 ticks -> o_mode=0, no o_ld, o_clk_en active on next tick.
//  6 Assert i_rst in SET_MM after 2 incs -> o_mode=0, o_ld=0, o_ld_hh/mm=8'h00, no load pulse.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-set controller for the 12-hour HH:MM:SS clock: gates the 1 Hz run enable and runs the
// button-driven hours/minutes set sequence, finishing with a one-cycle parallel load.
module clock_set_ctrl #(
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_CYC = 5_000_000,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic       i_pm,
    output logic       o_clk_en,
    output logic       o_ld,
    output logic [7:0] o_ld_hh,
    output logic [7:0] o_ld_mm,
    output logic [7:0] o_ld_ss,
    output logic       o_ld_pm,
    output logic [1:0] o_mode,
    output logic       o_blank_hh,
    output logic       o_blank_mm
);

    localparam int unsigned HoldMax = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);
    localparam int unsigned TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [HoldW-1:0] DlyCnt  = HoldW'(REPEAT_DLY);
    localparam logic [HoldW-1:0] CycCnt  = HoldW'(REPEAT_CYC);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHh  = 2'd1,
        StSetMm  = 2'd2,
        StCommit = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             mode_prev_q, inc_prev_q;
    logic [7:0]       sh_hh_q, sh_hh_d;
    logic [7:0]       sh_mm_q, sh_mm_d;
    logic             sh_pm_q, sh_pm_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             hold_act_q, hold_act_d;
    logic             rep_q, rep_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             toggle_q, toggle_d;
    logic             ld_q, ld_d;
    logic             blank_hh_q, blank_hh_d;
    logic             blank_mm_q, blank_mm_d;

    logic mode_p, inc_p, in_set, rep_fire, step;

    // 12-hour BCD hours advance; the 11 -> 00 wrap is handled by the caller to flip PM.
    function automatic logic [7:0] hh_inc(input logic [7:0] v);
        if (v == 8'h11) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] mm_inc(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign mode_p = i_btn_mode & ~mode_prev_q;
    assign inc_p  = i_btn_inc & ~inc_prev_q;
    assign in_set = (state_q == StSetHh) || (state_q == StSetMm);

    // Repeat phase compares against the shorter period once the initial delay has elapsed.
    assign rep_fire = in_set & i_btn_inc & hold_act_q & ~inc_p &
                      (hold_q == (rep_q ? CycCnt : DlyCnt));
    assign step     = in_set & (inc_p | rep_fire) & ~mode_p;

    always_comb begin
        state_d    = state_q;
        sh_hh_d    = sh_hh_q;
        sh_mm_d    = sh_mm_q;
        sh_pm_d    = sh_pm_q;
        tmo_d      = tmo_q;
        toggle_d   = toggle_q;
        hold_d     = hold_q;
        hold_act_d = hold_act_q;
        rep_d      = rep_q;

        unique case (state_q)
            StRun: begin
                tmo_d = '0;
                if (mode_p) begin
                    sh_hh_d = i_hh;
                    sh_mm_d = i_mm;
                    sh_pm_d = i_pm;
                    state_d = StSetHh;
                end
            end
            StSetHh, StSetMm: begin
                if (step) begin
                    if (state_q == StSetHh) begin
                        sh_hh_d = hh_inc(sh_hh_q);
                        if (sh_hh_q == 8'h11) sh_pm_d = ~sh_pm_q;
                    end else begin
                        sh_mm_d = mm_inc(sh_mm_q);
                    end
                end

                if (step) toggle_d = 1'b0;
                else if (i_tick) toggle_d = ~toggle_q;

                if (mode_p || inc_p) begin
                    tmo_d = '0;
                end else if (i_tick) begin
                    if (tmo_q == TmoLast) begin
                        tmo_d   = '0;
                        state_d = StRun;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end

                if (mode_p) state_d = (state_q == StSetHh) ? StSetMm : StCommit;
            end
            StCommit: begin
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        // Auto-repeat only arms on a fresh inc edge within the current set state.
        if (!(in_set && i_btn_inc) || (state_d != state_q)) begin
            hold_d     = '0;
            hold_act_d = 1'b0;
            rep_d      = 1'b0;
        end else if (inc_p) begin
            hold_d     = HoldW'(1);
            hold_act_d = 1'b1;
            rep_d      = 1'b0;
        end else if (hold_act_q) begin
            if (rep_fire) begin
                hold_d = HoldW'(1);
                rep_d  = 1'b1;
            end else begin
                hold_d = hold_q + HoldW'(1);
            end
        end

        if ((state_d == StRun) || (state_d == StCommit)) toggle_d = 1'b0;

        ld_d       = (state_d == StCommit);
        blank_hh_d = toggle_d & (state_d == StSetHh);
        blank_mm_d = toggle_d & (state_d == StSetMm);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StRun;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            sh_hh_q     <= 8'h00;
            sh_mm_q     <= 8'h00;
            sh_pm_q     <= 1'b0;
            hold_q      <= '0;
            hold_act_q  <= 1'b0;
            rep_q       <= 1'b0;
            tmo_q       <= '0;
            toggle_q    <= 1'b0;
            ld_q        <= 1'b0;
            blank_hh_q  <= 1'b0;
            blank_mm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= i_btn_mode;
            inc_prev_q  <= i_btn_inc;
            sh_hh_q     <= sh_hh_d;
            sh_mm_q     <= sh_mm_d;
            sh_pm_q     <= sh_pm_d;
            hold_q      <= hold_d;
            hold_act_q  <= hold_act_d;
            rep_q       <= rep_d;
            tmo_q       <= tmo_d;
            toggle_q    <= toggle_d;
            ld_q        <= ld_d;
            blank_hh_q  <= blank_hh_d;
            blank_mm_q  <= blank_mm_d;
        end
    end

    assign o_clk_en   = i_tick & (state_q == StRun) & i_rst;
    assign o_ld       = ld_q;
    assign o_ld_hh    = sh_hh_q;
    assign o_ld_mm    = sh_mm_q;
    assign o_ld_ss    = 8'h00;
    assign o_ld_pm    = sh_pm_q;
    assign o_mode     = state_q;
    assign o_blank_hh = blank_hh_q;
    assign o_blank_mm = blank_mm_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, directed corner sequences and a random run checked
// against a behavioural model of the set sequence kept in plain integers.
module tb_clock_set_ctrl;

    localparam int DLY = 8;
    localparam int CYC = 4;
    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick, bm, bi;
    logic [7:0] hh, mm;
    logic       pm;
    logic       o_clk_en, o_ld, o_ld_pm, o_blank_hh, o_blank_mm;
    logic [7:0] o_ld_hh, o_ld_mm, o_ld_ss;
    logic [1:0] o_mode;

    clock_set_ctrl #(
        .REPEAT_DLY(DLY),
        .REPEAT_CYC(CYC),
        .TIMEOUT   (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_tick    (tick),
        .i_btn_mode(bm),
        .i_btn_inc (bi),
        .i_hh      (hh),
        .i_mm      (mm),
        .i_pm      (pm),
        .o_clk_en  (o_clk_en),
        .o_ld      (o_ld),
        .o_ld_hh   (o_ld_hh),
        .o_ld_mm   (o_ld_mm),
        .o_ld_ss   (o_ld_ss),
        .o_ld_pm   (o_ld_pm),
        .o_mode    (o_mode),
        .o_blank_hh(o_blank_hh),
        .o_blank_mm(o_blank_mm)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Stimulus state
    bit         tick_en = 0;
    int         tcnt = 0;
    logic [7:0] nhh = 8'h00, nmm = 8'h00;
    logic       npm = 1'b0;

    // Model: state 0 run, 1 hours, 2 minutes, 3 load; shadow kept as plain decimal numbers
    int st, sh_h, sh_m, k, tmo;
    bit sh_pm, tog, prev_m, prev_i;

    typedef struct {
        logic m;
        logic inc;
        int   e_mode;
        logic e_ld;
        int   e_hh;
        int   e_mm;
        logic e_pm;
    } vec_t;

    vec_t vt[16];

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int unbcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        st = 0; sh_h = 0; sh_m = 0; sh_pm = 0; tog = 0; k = -1; tmo = 0;
        prev_m = 0; prev_i = 0;
    endtask

    task automatic model_step();
        bit mp, ip, set, fire, stp;
        int nst;
        mp   = bm && !prev_m;
        ip   = bi && !prev_i;
        set  = (st == 1) || (st == 2);
        fire = 0;
        if (set && bi) begin
            if (ip) k = 0;
            else if (k >= 0) begin
                k++;
                fire = (k == DLY) || (k > DLY && ((k - DLY) % CYC) == 0);
            end
        end else begin
            k = -1;
        end
        stp = set && (ip || fire) && !mp;
        nst = st;
        if (st == 0) begin
            if (mp) begin
                sh_h = unbcd(hh); sh_m = unbcd(mm); sh_pm = pm; nst = 1; tmo = 0;
            end
        end else if (set) begin
            if (stp && st == 1) begin
                if (sh_h == 11) begin sh_h = 0; sh_pm = !sh_pm; end
                else sh_h++;
            end
            if (stp && st == 2) sh_m = (sh_m + 1) % 60;
            if (stp) tog = 0;
            else if (tick) tog = !tog;
            if (mp || ip) tmo = 0;
            else if (tick) begin
                tmo++;
                if (tmo >= TMO) begin nst = 0; tmo = 0; end
            end
            if (mp) nst = st + 1;
        end else begin
            nst = 0;
        end
        if (nst != st) k = -1;
        if (nst == 0 || nst == 3) tog = 0;
        st = nst;
        prev_m = bm;
        prev_i = bi;
    endtask

    task automatic check_outputs();
        chk("mode", int'(o_mode), st);
        chk("ld", int'(o_ld), int'(st == 3));
        chk("ld_ss", int'(o_ld_ss), 0);
        chk("clk_en", int'(o_clk_en), int'(tick && st == 0));
        chk("blank_hh", int'(o_blank_hh), int'(tog && st == 1));
        chk("blank_mm", int'(o_blank_mm), int'(tog && st == 2));
        if (st != 0) begin
            chk("shadow_hh", int'(o_ld_hh), bcd(sh_h));
            chk("shadow_mm", int'(o_ld_mm), bcd(sh_m));
            chk("shadow_pm", int'(o_ld_pm), int'(sh_pm));
        end
    endtask

    // One clock: inputs applied on the falling edge, outputs compared before the rising edge.
    task automatic cycle(input logic m, input logic inc);
        @(negedge clk);
        bm = m; bi = inc; hh = nhh; mm = nmm; pm = npm;
        tick = tick_en && (tcnt == 9);
        tcnt = (tcnt + 1) % 10;
        #1;
        check_outputs();
        model_step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lds, tk;
        bit done;
        logic lvl;

        rst_n = 0; tick = 0; bm = 0; bi = 0; hh = 8'h10; mm = 8'h58; pm = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", int'(o_mode), 0);
        chk("rst_ld", int'(o_ld), 0);
        chk("rst_ld_hh", int'(o_ld_hh), 0);
        chk("rst_ld_mm", int'(o_ld_mm), 0);
        chk("rst_ld_pm", int'(o_ld_pm), 0);
        chk("rst_blank", int'({o_blank_hh, o_blank_mm}), 0);
        @(negedge clk);
        rst_n = 1;

        // Run mode: five ticks pass straight through
        tick_en = 1; tcnt = 0; cnt = 0; lds = 0;
        repeat (50) begin
            cycle(0, 0);
            if (o_clk_en) cnt++;
            if (o_ld) lds++;
        end
        chk("run_clk_en_pulses", cnt, 5);
        chk("run_no_ld", lds, 0);

        // Full set sequence from 10:58 AM through both wraps
        tick_en = 0; nhh = 8'h10; nmm = 8'h58; npm = 0;
        vt[0]  = '{0, 0, 0, 0, 'h10, 'h58, 0};
        vt[1]  = '{1, 0, 0, 0, 'h10, 'h58, 0};
        vt[2]  = '{0, 0, 1, 0, 'h10, 'h58, 0};
        vt[3]  = '{0, 1, 1, 0, 'h10, 'h58, 0};
        vt[4]  = '{0, 0, 1, 0, 'h11, 'h58, 0};
        vt[5]  = '{0, 1, 1, 0, 'h11, 'h58, 0};
        vt[6]  = '{0, 0, 1, 0, 'h00, 'h58, 1};
        vt[7]  = '{1, 0, 1, 0, 'h00, 'h58, 1};
        vt[8]  = '{0, 0, 2, 0, 'h00, 'h58, 1};
        vt[9]  = '{0, 1, 2, 0, 'h00, 'h58, 1};
        vt[10] = '{0, 0, 2, 0, 'h00, 'h59, 1};
        vt[11] = '{0, 1, 2, 0, 'h00, 'h59, 1};
        vt[12] = '{0, 0, 2, 0, 'h00, 'h00, 1};
        vt[13] = '{1, 0, 2, 0, 'h00, 'h00, 1};
        vt[14] = '{0, 0, 3, 1, 'h00, 'h00, 1};
        vt[15] = '{0, 0, 0, 0, 'h00, 'h00, 1};
        lds = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(vt[i].m, vt[i].inc);
            if (o_ld) lds++;
            chk($sformatf("vec%0d_mode", i), int'(o_mode), vt[i].e_mode);
            chk($sformatf("vec%0d_ld", i), int'(o_ld), int'(vt[i].e_ld));
            if (vt[i].e_mode != 0) begin
                chk($sformatf("vec%0d_hh", i), int'(o_ld_hh), vt[i].e_hh);
                chk($sformatf("vec%0d_mm", i), int'(o_ld_mm), vt[i].e_mm);
                chk($sformatf("vec%0d_pm", i), int'(o_ld_pm), int'(vt[i].e_pm));
            end
            if (vt[i].e_ld) chk($sformatf("vec%0d_ss", i), int'(o_ld_ss), 0);
        end
        chk("set_one_ld", lds, 1);
        tick_en = 1; tcnt = 0; done = 0;
        for (int i = 0; i < 25 && !done; i++) begin
            cycle(0, 0);
            if (o_clk_en) done = 1;
        end
        chk("clk_en_resumes", int'(done), 1);

        // Auto-repeat from 07 in minutes: edge, +8, +12, +16, +20
        tick_en = 0; nhh = 8'h03; nmm = 8'h07; npm = 0;
        cycle(0, 0); cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
        chk("rep_in_set_mm", int'(o_mode), 2);
        chk("rep_start_mm", int'(o_ld_mm), 'h07);
        repeat (21) cycle(0, 1);
        cycle(0, 0);
        chk("rep_final_mm", int'(o_ld_mm), 'h12);

        // Mode and inc rising together: mode wins
        cycle(1, 0); cycle(0, 0); cycle(0, 0);
        cycle(1, 0); cycle(0, 0);
        chk("both_pre_mode", int'(o_mode), 1);
        cycle(1, 1); cycle(0, 0);
        chk("both_mode", int'(o_mode), 2);
        chk("both_hh", int'(o_ld_hh), 'h03);

        // Idle timeout in hours
        cycle(1, 0); cycle(0, 0); cycle(0, 0);
        cycle(1, 0); cycle(0, 0);
        chk("tmo_in_set_hh", int'(o_mode), 1);
        tick_en = 1; tcnt = 0; done = 0; tk = 0; lds = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle(0, 0);
            if (o_ld) lds++;
            if (o_mode == 2'd0) done = 1;
            else if (tick) tk++;
        end
        chk("tmo_to_run", int'(done), 1);
        chk("tmo_ticks", tk, TMO);
        chk("tmo_no_ld", lds, 0);
        done = 0;
        for (int i = 0; i < 15 && !done; i++) begin
            cycle(0, 0);
            if (tick) begin
                done = 1;
                chk("tmo_clk_en", int'(o_clk_en), 1);
            end
        end
        chk("tmo_tick_seen", int'(done), 1);

        // Async reset in the middle of minute editing
        tick_en = 0;
        cycle(1, 0); cycle(0, 0); cycle(1, 0); cycle(0, 0);
        cycle(0, 1); cycle(0, 0); cycle(0, 1); cycle(0, 0);
        chk("arst_pre_mode", int'(o_mode), 2);
        chk("arst_pre_mm", int'(o_ld_mm), 'h09);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_mode", int'(o_mode), 0);
        chk("arst_ld", int'(o_ld), 0);
        chk("arst_hh", int'(o_ld_hh), 0);
        chk("arst_mm", int'(o_ld_mm), 0);
        lds = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_ld) lds++;
        end
        chk("arst_no_ld", lds, 0);
        @(negedge clk);
        rst_n = 1; bm = 0; bi = 0;
        model_reset();
        repeat (4) begin
            cycle(0, 0);
            if (o_ld) lds++;
        end
        chk("arst_after_no_ld", lds, 0);

        // Randomised run against the model
        tick_en = 1; lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) lvl = ~lvl;
            if (st == 0 && $urandom_range(0, 29) == 0) begin
                nhh = 8'(bcd($urandom_range(0, 11)));
                nmm = 8'(bcd($urandom_range(0, 59)));
                npm = 1'($urandom_range(0, 1));
            end
            cycle(1'($urandom_range(0, 11) == 0), lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
